// File: rtl/dll_rx_demux.sv
// dll_rx_demux: splits EP beats into a 2-entry TLP FIFO and decoded DLLP state (flags, credits, Ack/Nak, drops).
module dll_rx_demux #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             link_up_i,
    input  logic [255:0]     ep_data_i,
    input  logic             ep2dll_valid_i,
    output logic             dll2ep_ready_o,
    output logic [255:0]     rx_tlp_data_o,
    output logic             rx_tlp_valid_o,
    input  logic             rx_tlp_ready_i,
    output logic [2:0]       initfc1_flags_o,
    output logic [2:0]       initfc2_flags_o,
    output logic [3:0]       p_credit_o,
    output logic [3:0]       np_credit_o,
    output logic [3:0]       cpl_credit_o,
    output logic             ack_o,
    output logic             nak_o,
    output logic [11:0]      ackseq_o,
    output logic [CNT_W-1:0] drop_cnt_o
);
    logic [255:0]     mem_q [FIFO_DEPTH];
    logic [255:0]     mem_d [FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [2:0]       fc1_q, fc1_d, fc2_q, fc2_d;
    logic [2:0][3:0]  cred_q, cred_d;
    logic             ack_q, ack_d, nak_q, nak_d;
    logic [11:0]      seq_q, seq_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             acc, push, pop, dllp, drop;
    logic [7:0]       typ;

    // Ready gates DLLPs too, so a DLLP never overtakes a stalled TLP.
    assign dll2ep_ready_o  = rst_n && link_up_i && (cnt_q != 2'(FIFO_DEPTH));
    assign rx_tlp_valid_o  = cnt_q != 2'd0;
    assign rx_tlp_data_o   = rx_tlp_valid_o ? mem_q[rd_ptr_q] : '0;
    assign initfc1_flags_o = fc1_q;
    assign initfc2_flags_o = fc2_q;
    assign p_credit_o      = cred_q[0];
    assign np_credit_o     = cred_q[1];
    assign cpl_credit_o    = cred_q[2];
    assign ack_o           = ack_q;
    assign nak_o           = nak_q;
    assign ackseq_o        = seq_q;
    assign drop_cnt_o      = drop_q;

    always_comb begin
        acc      = ep2dll_valid_i && dll2ep_ready_o;
        push     = acc && !ep_data_i[255];
        dllp     = acc && ep_data_i[255];
        pop      = rx_tlp_valid_o && rx_tlp_ready_i;
        typ      = ep_data_i[7:0];
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = {1'b0, ep_data_i[254:0]};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        fc1_d    = fc1_q;
        fc2_d    = fc2_q;
        cred_d   = cred_q;
        ack_d    = dllp && typ == 8'h0A;
        nak_d    = dllp && typ == 8'h0B;
        seq_d    = (ack_d || nak_d) ? ep_data_i[19:8] : seq_q;
        drop     = dllp && (typ == 8'h00 || typ > 8'h0B);
        for (int i = 0; i < 3; i++) begin
            if (dllp && typ == 8'(i + 1) && !fc1_q[i]) begin
                fc1_d[i]  = 1'b1;
                cred_d[i] = ep_data_i[11:8];
            end
            if (dllp && typ == 8'(i + 4)) begin
                if (&fc1_q) fc2_d[i] = 1'b1;
                else drop = 1'b1;
            end
            if (dllp && typ == 8'(i + 7)) begin
                if (&fc2_q) cred_d[i] = ep_data_i[11:8];
                else drop = 1'b1;
            end
        end
        drop_d   = drop_q + CNT_W'(drop && !(&drop_q));
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk) begin
        if (!rst_n || !link_up_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            fc1_q    <= '0;
            fc2_q    <= '0;
            cred_q   <= '0;
            ack_q    <= 1'b0;
            nak_q    <= 1'b0;
            seq_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            fc1_q    <= fc1_d;
            fc2_q    <= fc2_d;
            cred_q   <= cred_d;
            ack_q    <= ack_d;
            nak_q    <= nak_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
        end
    end
endmodule

// File: tb/tb_dll_rx_demux.sv
// tb_dll_rx_demux: directed vector table plus a drop-counter saturation sequence.
module tb_dll_rx_demux;
    logic         clk = 1'b0;
    logic         rst_n, link_up_i, ep2dll_valid_i, rx_tlp_ready_i;
    logic [255:0] ep_data_i;
    logic         dll2ep_ready_o, rx_tlp_valid_o, ack_o, nak_o;
    logic [255:0] rx_tlp_data_o;
    logic [2:0]   initfc1_flags_o, initfc2_flags_o;
    logic [3:0]   p_credit_o, np_credit_o, cpl_credit_o;
    logic [11:0]  ackseq_o;
    logic [7:0]   drop_cnt_o;
    int           n_vec = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    dll_rx_demux #(.FIFO_DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .link_up_i(link_up_i), .ep_data_i(ep_data_i),
        .ep2dll_valid_i(ep2dll_valid_i), .dll2ep_ready_o(dll2ep_ready_o),
        .rx_tlp_data_o(rx_tlp_data_o), .rx_tlp_valid_o(rx_tlp_valid_o),
        .rx_tlp_ready_i(rx_tlp_ready_i), .initfc1_flags_o(initfc1_flags_o),
        .initfc2_flags_o(initfc2_flags_o), .p_credit_o(p_credit_o),
        .np_credit_o(np_credit_o), .cpl_credit_o(cpl_credit_o), .ack_o(ack_o),
        .nak_o(nak_o), .ackseq_o(ackseq_o), .drop_cnt_o(drop_cnt_o)
    );

    typedef struct {
        logic        rst_n, lu, vld, isd;
        logic [7:0]  typ;
        logic [11:0] fld;
        logic        trdy;
        logic [62:0] exp;
    } vec_t;

    // {ready, valid, upper-data-nonzero, data[19:0], fc1, fc2, p, np, cpl, ack, nak, seq, drop}
    function automatic logic [62:0] ex(logic rdy, logic tv, logic [19:0] d, logic [2:0] f1, logic [2:0] f2,
                                       logic [3:0] p, logic [3:0] np, logic [3:0] cpl, logic a, logic n,
                                       logic [11:0] seq, logic [7:0] drp);
        return {rdy, tv, 1'b0, d, f1, f2, p, np, cpl, a, n, seq, drp};
    endfunction

    function automatic vec_t v(logic r, logic lu, logic vld, logic isd, logic [7:0] typ,
                               logic [11:0] fld, logic trdy, logic [62:0] e);
        vec_t x;
        x.rst_n = r; x.lu = lu; x.vld = vld; x.isd = isd;
        x.typ = typ; x.fld = fld; x.trdy = trdy; x.exp = e;
        return x;
    endfunction

    function automatic logic [62:0] act();
        return {dll2ep_ready_o, rx_tlp_valid_o, |rx_tlp_data_o[255:20], rx_tlp_data_o[19:0],
                initfc1_flags_o, initfc2_flags_o, p_credit_o, np_credit_o, cpl_credit_o,
                ack_o, nak_o, ackseq_o, drop_cnt_o};
    endfunction

    task automatic chk(string name, logic [62:0] got, logic [62:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    vec_t tbl[39];

    initial begin
        tbl[0]  = v(0,1,0,0,8'h00,12'h000,0, ex(0,0,20'h0,0,0,0,0,0,0,0,12'h000,0));
        tbl[1]  = v(1,1,0,0,8'h00,12'h000,0, ex(1,0,20'h0,0,0,0,0,0,0,0,12'h000,0));
        tbl[2]  = v(1,1,1,1,8'h01,12'h008,0, ex(1,0,20'h0,1,0,8,0,0,0,0,12'h000,0));
        tbl[3]  = v(1,1,1,1,8'h02,12'h004,0, ex(1,0,20'h0,3,0,8,4,0,0,0,12'h000,0));
        tbl[4]  = v(1,1,1,1,8'h04,12'h000,0, ex(1,0,20'h0,3,0,8,4,0,0,0,12'h000,1));
        tbl[5]  = v(1,1,1,1,8'h03,12'h004,0, ex(1,0,20'h0,7,0,8,4,4,0,0,12'h000,1));
        tbl[6]  = v(1,1,1,1,8'h01,12'h002,0, ex(1,0,20'h0,7,0,8,4,4,0,0,12'h000,1));
        tbl[7]  = v(1,1,1,1,8'h07,12'h005,0, ex(1,0,20'h0,7,0,8,4,4,0,0,12'h000,2));
        tbl[8]  = v(1,1,1,1,8'h04,12'h000,0, ex(1,0,20'h0,7,1,8,4,4,0,0,12'h000,2));
        tbl[9]  = v(1,1,1,1,8'h05,12'h000,0, ex(1,0,20'h0,7,3,8,4,4,0,0,12'h000,2));
        tbl[10] = v(1,1,1,1,8'h06,12'h000,0, ex(1,0,20'h0,7,7,8,4,4,0,0,12'h000,2));
        tbl[11] = v(1,1,1,1,8'h07,12'h005,0, ex(1,0,20'h0,7,7,5,4,4,0,0,12'h000,2));
        tbl[12] = v(1,1,1,1,8'h08,12'h00A,0, ex(1,0,20'h0,7,7,5,10,4,0,0,12'h000,2));
        tbl[13] = v(1,1,1,1,8'h09,12'h00F,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h000,2));
        tbl[14] = v(1,1,1,1,8'h00,12'h000,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h000,3));
        tbl[15] = v(1,1,1,1,8'h0C,12'h000,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h000,4));
        tbl[16] = v(1,1,1,1,8'hFF,12'h000,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h000,5));
        tbl[17] = v(1,1,1,1,8'h0A,12'h123,0, ex(1,0,20'h0,7,7,5,10,15,1,0,12'h123,5));
        tbl[18] = v(1,1,1,1,8'h0B,12'h456,0, ex(1,0,20'h0,7,7,5,10,15,0,1,12'h456,5));
        tbl[19] = v(1,1,0,0,8'h00,12'h000,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h456,5));
        tbl[20] = v(1,1,1,1,8'h0A,12'h001,0, ex(1,0,20'h0,7,7,5,10,15,1,0,12'h001,5));
        tbl[21] = v(1,1,1,1,8'h0A,12'h002,0, ex(1,0,20'h0,7,7,5,10,15,1,0,12'h002,5));
        tbl[22] = v(1,1,0,0,8'h00,12'h000,0, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h002,5));
        tbl[23] = v(1,1,1,0,8'h11,12'hA01,0, ex(1,1,20'hA0111,7,7,5,10,15,0,0,12'h002,5));
        tbl[24] = v(1,1,1,0,8'h22,12'hB02,0, ex(0,1,20'hA0111,7,7,5,10,15,0,0,12'h002,5));
        tbl[25] = v(1,1,1,0,8'h33,12'hC03,0, ex(0,1,20'hA0111,7,7,5,10,15,0,0,12'h002,5));
        tbl[26] = v(1,1,1,0,8'h33,12'hC03,1, ex(1,1,20'hB0222,7,7,5,10,15,0,0,12'h002,5));
        tbl[27] = v(1,1,1,0,8'h33,12'hC03,0, ex(0,1,20'hB0222,7,7,5,10,15,0,0,12'h002,5));
        tbl[28] = v(1,1,0,0,8'h00,12'h000,1, ex(1,1,20'hC0333,7,7,5,10,15,0,0,12'h002,5));
        tbl[29] = v(1,1,0,0,8'h00,12'h000,1, ex(1,0,20'h0,7,7,5,10,15,0,0,12'h002,5));
        tbl[30] = v(1,1,1,0,8'h44,12'hD04,1, ex(1,1,20'hD0444,7,7,5,10,15,0,0,12'h002,5));
        tbl[31] = v(1,1,1,0,8'h55,12'hE05,1, ex(1,1,20'hE0555,7,7,5,10,15,0,0,12'h002,5));
        tbl[32] = v(1,1,0,0,8'h00,12'h000,0, ex(1,1,20'hE0555,7,7,5,10,15,0,0,12'h002,5));
        tbl[33] = v(1,1,1,1,8'h0A,12'h7FF,0, ex(1,1,20'hE0555,7,7,5,10,15,1,0,12'h7FF,5));
        tbl[34] = v(1,1,1,0,8'h66,12'hF06,0, ex(0,1,20'hE0555,7,7,5,10,15,0,0,12'h7FF,5));
        tbl[35] = v(1,1,1,1,8'h0A,12'h100,0, ex(0,1,20'hE0555,7,7,5,10,15,0,0,12'h7FF,5));
        tbl[36] = v(1,0,0,0,8'h00,12'h000,0, ex(0,0,20'h0,0,0,0,0,0,0,0,12'h000,0));
        tbl[37] = v(1,1,0,0,8'h00,12'h000,0, ex(1,0,20'h0,0,0,0,0,0,0,0,12'h000,0));
        tbl[38] = v(1,1,0,0,8'h00,12'h000,1, ex(1,0,20'h0,0,0,0,0,0,0,0,12'h000,0));

        rst_n = 1'b0; link_up_i = 1'b1; ep2dll_valid_i = 1'b0; rx_tlp_ready_i = 1'b0; ep_data_i = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            rst_n          = tbl[i].rst_n;
            link_up_i      = tbl[i].lu;
            ep2dll_valid_i = tbl[i].vld;
            rx_tlp_ready_i = tbl[i].trdy;
            ep_data_i      = {tbl[i].isd, 235'b0, tbl[i].fld, tbl[i].typ};
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), act(), tbl[i].exp);
        end

        // Drop counter saturation: 254, then 255, then stuck at 255.
        @(negedge clk);
        ep2dll_valid_i = 1'b1;
        rx_tlp_ready_i = 1'b0;
        ep_data_i      = {1'b1, 235'b0, 12'h000, 8'hEE};
        repeat (254) @(posedge clk);
        #1 chk("drop_254", 63'(drop_cnt_o), 63'd254);
        @(posedge clk);
        #1 chk("drop_255", 63'(drop_cnt_o), 63'd255);
        repeat (5) @(posedge clk);
        #1 chk("drop_sat", 63'(drop_cnt_o), 63'd255);
        chk("drop_no_tlp", 63'({rx_tlp_valid_o, ack_o, nak_o}), 63'd0);
        @(negedge clk);
        ep2dll_valid_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
